// File: rtl/cpu_types_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_types_pkg
//  Description : Shared types for the 5-stage core: the hazard controller
//                state encoding, the register-index type and the hard-wired
//                zero register index.
//  Revision    : 1.0 - initial release
// ============================================================================
package cpu_types_pkg;

    localparam int REG_W = 5;

    typedef logic [REG_W-1:0] regbits_t;

    localparam regbits_t REG_ZERO = '0;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DWAIT = 2'd1,
        HALT  = 2'd2
    } hzd_state_t;

endpackage : cpu_types_pkg
`default_nettype wire

// File: rtl/hazard_perf_ctr.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_perf_ctr
//  Description : One saturating event counter. Counts clock cycles on which
//                'inc' is high and sticks at all-ones.
//  Ports       : CLK   - clock
//                RST   - synchronous active-high reset, clears the count
//                inc   - count enable for this cycle
//                count - current count (CNT_W bits)
//  Revision    : 1.0 - initial release
// ============================================================================
module hazard_perf_ctr #(
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge CLK) begin
        if (RST) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule : hazard_perf_ctr
`default_nettype wire

// File: rtl/hazard_unit.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_unit
//  Description : Pipeline stall/flush controller for the 5-stage core.
//                Handles halt, data-memory wait, taken-branch squash,
//                load-use and instruction-memory wait, highest priority
//                first. Outputs are a zero-latency (Mealy) function of the
//                state register and the current inputs.
//  Ports       : CLK, RST          - clock, synchronous active-high reset
//                id_rs, id_rt      - source registers of the ID instruction
//                ex_rd, ex_memRead - destination / is-load of EX instruction
//                ex_branch_tkn     - branch/jump resolved taken in EX
//                mem_dREN/dWEN     - MEM stage data access request
//                dhit, ihit        - data / instruction access complete
//                wb_halt           - halt instruction reached WB
//                *_en, *_flush     - latch enables and bubble loads
//                halted            - sticky core-halted flag
//  Config      : HAZARD_PERF_EN adds saturating counters stall_cycles,
//                loaduse_cnt and flush_cnt (CNT_W bits each).
//  Revision    : 1.0 - initial release
// ============================================================================
module hazard_unit
    import cpu_types_pkg::*;
#(
    parameter int REG_W = 5
`ifdef HAZARD_PERF_EN
    ,
    parameter int CNT_W = 32
`endif
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             ex_memRead,
    input  logic             ex_branch_tkn,
    input  logic             mem_dREN,
    input  logic             mem_dWEN,
    input  logic             dhit,
    input  logic             ihit,
    input  logic             wb_halt,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             id_ex_en,
    output logic             ex_mem_en,
    output logic             mem_wb_en,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             mem_wb_flush,
    output logic             halted
`ifdef HAZARD_PERF_EN
    ,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] loaduse_cnt,
    output logic [CNT_W-1:0] flush_cnt
`endif
);

    hzd_state_t r_state;
    hzd_state_t w_next_state;
    logic       w_load_use;
    logic       w_dmem_wait;

    // Register 0 is hard-wired zero, so a load targeting it never creates
    // a real dependency.
    assign w_load_use = ex_memRead && (ex_rd != REG_W'(REG_ZERO)) &&
                        ((ex_rd == id_rs) || (ex_rd == id_rt));

    // Once waiting, only dhit releases the freeze; the request lines of the
    // frozen MEM instruction are not re-qualified.
    assign w_dmem_wait = (r_state == DWAIT) ? !dhit
                                            : ((mem_dREN || mem_dWEN) && !dhit);

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= RUN;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        pc_en        = 1'b1;
        if_id_en     = 1'b1;
        id_ex_en     = 1'b1;
        ex_mem_en    = 1'b1;
        mem_wb_en    = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        mem_wb_flush = 1'b0;
        halted       = 1'b0;
        w_next_state = r_state;

        if (RST) begin
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_en     = 1'b0;
            ex_mem_en    = 1'b0;
            mem_wb_en    = 1'b0;
            w_next_state = RUN;
        end else if (r_state == HALT) begin
            pc_en     = 1'b0;
            if_id_en  = 1'b0;
            id_ex_en  = 1'b0;
            ex_mem_en = 1'b0;
            mem_wb_en = 1'b0;
            halted    = 1'b1;
        end else if ((r_state == RUN) && wb_halt) begin
            // Freeze immediately so nothing behind the halt retires.
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_en     = 1'b0;
            ex_mem_en    = 1'b0;
            mem_wb_en    = 1'b0;
            halted       = 1'b1;
            w_next_state = HALT;
        end else if (w_dmem_wait) begin
            // Front of the pipe holds; WB receives bubbles. Any ihit seen
            // now is dropped and IF refetches the held PC.
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_en     = 1'b0;
            ex_mem_en    = 1'b0;
            mem_wb_flush = 1'b1;
            w_next_state = DWAIT;
        end else begin
            // The dhit release cycle from DWAIT lands here too, so a branch
            // or load-use sitting behind the frozen access is still honoured.
            w_next_state = RUN;
            if (ex_branch_tkn) begin
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
            end else if (w_load_use) begin
                // Hold IF/ID without flushing even if IF is also waiting,
                // otherwise the stalled ID instruction would be lost.
                pc_en       = 1'b0;
                if_id_en    = 1'b0;
                id_ex_flush = 1'b1;
            end else if (!ihit) begin
                pc_en       = 1'b0;
                if_id_flush = 1'b1;
            end
        end
    end

`ifdef HAZARD_PERF_EN
    logic w_stall_inc;
    logic w_loaduse_inc;
    logic w_flush_inc;

    // Event decode from the control outputs: a squash flushes both IF/ID
    // and ID/EX, a load-use bubble flushes ID/EX alone.
    assign w_stall_inc   = !pc_en && !halted && !RST;
    assign w_loaduse_inc = id_ex_flush && !if_id_flush;
    assign w_flush_inc   = id_ex_flush && if_id_flush;

    hazard_perf_ctr #(.CNT_W(CNT_W)) u_stall_ctr (
        .CLK   (CLK),
        .RST   (RST),
        .inc   (w_stall_inc),
        .count (stall_cycles)
    );

    hazard_perf_ctr #(.CNT_W(CNT_W)) u_loaduse_ctr (
        .CLK   (CLK),
        .RST   (RST),
        .inc   (w_loaduse_inc),
        .count (loaduse_cnt)
    );

    hazard_perf_ctr #(.CNT_W(CNT_W)) u_flush_ctr (
        .CLK   (CLK),
        .RST   (RST),
        .inc   (w_flush_inc),
        .count (flush_cnt)
    );
`endif

endmodule : hazard_unit
`default_nettype wire
